// File: rtl/load_align_unit.sv
// Load path of the M stage: reads one or two words from a 1-cycle synchronous
// data memory, merges them, then aligns and sign/zero-extends the addressed bytes.
module load_align_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  output logic            mem_re,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err
);
  localparam int W    = XLEN / 8;
  localparam int OFFW = $clog2(W);
  localparam logic [4:0]           WB  = 5'(W);
  localparam logic [XLEN-OFFW-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, WAIT1, WAIT2, RESP} state_t;

  state_t               state, nstate;
  logic [2:0]           f3_q;
  logic [OFFW-1:0]      off_q;
  logic                 split_q;
  logic [XLEN-OFFW-1:0] base_q;
  logic [XLEN-1:0]      lo_q;

  logic                 accept, illegal, split, load_rsp, err_d;
  logic [4:0]           size;
  logic [XLEN-1:0]      rsp_d;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign size      = 5'd1 << funct3[1:0];
  assign illegal   = (size > WB) || (funct3 == 3'b111) || (funct3[2] && size == WB);
  assign split     = (5'(addr[OFFW-1:0]) + size) > WB;

  // Shift the {hi,lo} pair down to the addressed byte, then mask and extend.
  // The extension mask is empty for full-word loads, so they pass through.
  function automatic logic [XLEN-1:0] align(input logic [2*XLEN-1:0] pair,
                                            input logic [OFFW-1:0]   off,
                                            input logic [2:0]        f3);
    logic [2*XLEN-1:0] sh;
    logic [XLEN-1:0]   lo, mask, top;
    logic              sign;
    sh = pair >> {off, 3'b000};
    lo = sh[XLEN-1:0];
    case (f3[1:0])
      2'd0:    mask = XLEN'(8'hFF);
      2'd1:    mask = XLEN'(16'hFFFF);
      2'd2:    mask = XLEN'(32'hFFFF_FFFF);
      default: mask = '1;
    endcase
    top  = mask & ~(mask >> 1);
    sign = (|(lo & top)) & ~f3[2];
    return (lo & mask) | ({XLEN{sign}} & ~mask);
  endfunction

  always_comb begin
    nstate   = state;
    mem_re   = 1'b0;
    mem_addr = '0;
    load_rsp = 1'b0;
    err_d    = 1'b0;
    rsp_d    = '0;
    case (state)
      IDLE: if (req_valid) begin
        if (illegal) begin
          load_rsp = 1'b1;
          err_d    = 1'b1;
          nstate   = RESP;
        end else begin
          mem_re   = 1'b1;
          mem_addr = {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
          nstate   = WAIT1;
        end
      end
      WAIT1: if (split_q) begin
        mem_re   = 1'b1;
        mem_addr = {base_q + ONE, {OFFW{1'b0}}};
        nstate   = WAIT2;
      end else begin
        load_rsp = 1'b1;
        rsp_d    = align({{XLEN{1'b0}}, mem_rdata}, off_q, f3_q);
        nstate   = RESP;
      end
      WAIT2: begin
        load_rsp = 1'b1;
        rsp_d    = align({mem_rdata, lo_q}, off_q, f3_q);
        nstate   = RESP;
      end
      RESP: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      split_q   <= 1'b0;
      base_q    <= '0;
      lo_q      <= '0;
    end else begin
      state     <= nstate;
      rsp_valid <= load_rsp;
      if (load_rsp) begin
        rsp_data <= rsp_d;
        rsp_err  <= err_d;
      end
      if (accept) begin
        f3_q    <= funct3;
        off_q   <= addr[OFFW-1:0];
        split_q <= split;
        base_q  <= addr[XLEN-1:OFFW];
      end
      if (state == WAIT1) lo_q <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit (XLEN=32): byte-level reference model,
// expected memory reads and responses queued by the driver, checked by a monitor.
module tb_load_align_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  load_align_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .addr(addr), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] a; } rd_t;
  typedef struct { int cyc; logic [31:0] d; logic e; } rsp_t;
  rd_t  rq[$];
  rsp_t sq[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory contents: two fixed words, everything else a hash of the address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h100: return 32'h8765_43F1;
      32'h104: return 32'hCCBB_AA99;
      default: return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endcase
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    return 8'(w >> (8 * a[1:0]));
  endfunction

  always @(posedge clk) if (mem_re) mem_rdata <= word_at(mem_addr);

  // Reference: gather size bytes little-endian from consecutive addresses.
  function automatic void model(input logic [2:0] f3, input logic [31:0] a,
                                output logic [31:0] d, output bit err, output bit spl);
    int size;
    logic [63:0] v;
    size = 1 << f3[1:0];
    err  = (size > 4) || (f3 == 3'b111) || (f3[2] && size == 4);
    spl  = !err && (int'(a[1:0]) + size > 4);
    v    = '0;
    d    = '0;
    if (!err) begin
      for (int i = 0; i < size; i++) v = v | (64'(byte_at(a + 32'(i))) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((64'd1 << (8 * size)) - 64'd1);
      d = v[31:0];
    end
  endfunction

  always @(negedge clk) begin
    if (mem_re) begin
      if (rq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_mem_re: got addr 0x%0h expected none (cycle %0d)", mem_addr, cyc);
      end else begin
        rd_t r;
        r = rq.pop_front();
        check("mem_re_cycle", 64'(cyc), 64'(r.cyc));
        check("mem_addr", 64'(mem_addr), 64'(r.a));
      end
    end
    if (rsp_valid) begin
      if (sq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_rsp: got data 0x%0h expected no response (cycle %0d)", rsp_data, cyc);
      end else begin
        rsp_t s;
        s = sq.pop_front();
        check("rsp_cycle", 64'(cyc), 64'(s.cyc));
        check("rsp_data", 64'(rsp_data), 64'(s.d));
        check("rsp_err", 64'(rsp_err), 64'(s.e));
      end
    end
  end

  // Present a request, hold it until accepted, and queue the expected traffic.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input bit has_exp,
                       input logic [31:0] exp_d, input bit track_rsp);
    logic [31:0] d;
    bit e, s;
    int t, waited;
    model(f3, a, d, e, s);
    if (has_exp) d = exp_d;
    @(negedge clk);
    req_valid = 1'b1; funct3 = f3; addr = a;
    waited = 0;
    while (!req_ready && waited < 20) begin @(negedge clk); waited++; end
    check("req_ready_wait", 64'(req_ready), 64'd1);
    if (!req_ready) begin req_valid = 1'b0; return; end
    t = cyc;
    if (!e) begin
      rq.push_back('{t, {a[31:2], 2'b00}});
      if (s) rq.push_back('{t + 1, {a[31:2], 2'b00} + 32'd4});
    end
    if (track_rsp) sq.push_back('{t + (e ? 1 : (s ? 3 : 2)), d, e});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sq.size() != 0 || rq.size() != 0) && n < 50) begin @(negedge clk); n++; end
    check("queues_drained", 64'(sq.size() + rq.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    check("reset_rsp_err", 64'(rsp_err), 64'd0);
    check("reset_mem_re", 64'(mem_re), 64'd0);
    reset = 1'b0;

    issue(3'b000, 32'h100, 1, 32'hFFFF_FFF1, 1);
    issue(3'b100, 32'h103, 1, 32'h0000_0087, 1);
    issue(3'b101, 32'h101, 1, 32'h0000_6543, 1);
    issue(3'b001, 32'h102, 1, 32'hFFFF_8765, 1);
    issue(3'b010, 32'h102, 1, 32'hAA99_8765, 1);
    issue(3'b001, 32'h103, 1, 32'hFFFF_9987, 1);
    issue(3'b011, 32'h100, 1, 32'h0000_0000, 1);
    issue(3'b010, 32'h100, 1, 32'h8765_43F1, 1);
    issue(3'b110, 32'h104, 0, 32'h0, 1);
    issue(3'b111, 32'h105, 0, 32'h0, 1);
    issue(3'b010, 32'hFFFF_FFFE, 0, 32'h0, 1);
    issue(3'b001, 32'hFFFF_FFFF, 0, 32'h0, 1);
    drain();

    // Reset while the second word of a split load is in flight.
    issue(3'b010, 32'h102, 0, 32'h0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midsplit_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midsplit_rsp_data", 64'(rsp_data), 64'd0);
    check("midsplit_rsp_err", 64'(rsp_err), 64'd0);
    check("midsplit_mem_re", 64'(mem_re), 64'd0);
    check("midsplit_req_ready", 64'(req_ready), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_req_ready", 64'(req_ready), 64'd1);
    repeat (3) @(negedge clk);
    drain();

    for (int i = 0; i < 80; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else a = 32'h100 + 32'($urandom_range(0, 31));
      issue(f3, a, 0, 32'h0, 1);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
